// File: rtl/ghost_motion_ctrl.sv
// Per-ghost maze walker: queries the four neighbour tiles at each tile centre, picks a heading
// toward the target tile and steps one pixel per frame. GHOST_FRIGHTENED_EN adds random turns.
module ghost_motion_ctrl #(
    parameter logic [8:0] START_X    = 9'd104,
    parameter logic [8:0] START_Y    = 9'd112,
    parameter logic [1:0] START_DIR  = 2'd1,
    parameter logic [4:0] SCATTER_TX = 5'd25,
    parameter logic [5:0] SCATTER_TY = 6'd0,
    parameter int         MAZE_COLS  = 28,
    parameter int         MAZE_ROWS  = 36
) (
    input  logic       clk,
    input  logic       rst,
`ifdef GHOST_FRIGHTENED_EN
    input  logic       frightened,
`endif
    input  logic       frame_tick,
    input  logic       chase,
    input  logic [8:0] pac_x,
    input  logic [8:0] pac_y,
    output logic [9:0] wall_addr,
    input  logic       wall_bit,
    output logic [8:0] x,
    output logic [8:0] y,
    output logic [1:0] dir,
    output logic       busy
);
    localparam logic [1:0] D_UP = 2'd0, D_LEFT = 2'd1, D_DOWN = 2'd2, D_RIGHT = 2'd3;
    localparam logic [5:0] COL_LAST = 6'(MAZE_COLS - 1);
    localparam logic [8:0] X_LAST   = 9'(MAZE_COLS * 8 - 1);

    typedef enum logic [2:0] {S_IDLE, S_QADDR, S_QDATA, S_DECIDE, S_MOVE} state_t;

    state_t          state, nxt;
    logic [1:0]      k, qk;
    logic [3:0]      nb_open, nb_ok, cand;
    logic [3:0][5:0] nb_tx, nb_ty;
    logic [3:0][6:0] cost;
    logic [5:0]      tile_x, tile_y, tgt_x, tgt_y;
    logic [1:0]      rev, dir_new;
    logic [6:0]      best_cost;
    logic            aligned, accept, chase_q, mode_flag, found;
    logic            cap_en, dec_en, move_en;
    logic            unused_ok;

    assign unused_ok = &{1'b0, pac_x[2:0], pac_y[2:0]};

    function automatic logic [6:0] absdiff(input logic [5:0] a, input logic [5:0] b);
        return (a > b) ? 7'(a - b) : 7'(b - a);
    endfunction

    assign tile_x  = x[8:3];
    assign tile_y  = y[8:3];
    assign aligned = (x[2:0] == 3'd0) && (y[2:0] == 3'd0);
    // busy stays high for one cycle after MOVE, so a tick there is dropped
    assign accept  = (state == S_IDLE) && frame_tick && !busy;
    assign qk      = (state == S_QDATA) ? k + 2'd1 : 2'd0;

    // Neighbour tiles; columns wrap through the tunnel, rows off the map are walls
    always_comb begin
        nb_tx[0] = tile_x;
        nb_ty[0] = tile_y - 6'd1;
        nb_ok[0] = (tile_y != 6'd0);
        nb_tx[1] = (tile_x == 6'd0) ? COL_LAST : tile_x - 6'd1;
        nb_ty[1] = tile_y;
        nb_ok[1] = 1'b1;
        nb_tx[2] = tile_x;
        nb_ty[2] = tile_y + 6'd1;
        nb_ok[2] = (int'(tile_y) + 1 < MAZE_ROWS);
        nb_tx[3] = (tile_x == COL_LAST) ? 6'd0 : tile_x + 6'd1;
        nb_ty[3] = tile_y;
        nb_ok[3] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:   if (accept) nxt = aligned ? S_QADDR : S_MOVE;
            S_QADDR:  nxt = S_QDATA;
            S_QDATA:  nxt = (k == 2'd3) ? S_DECIDE : S_QADDR;
            S_DECIDE: nxt = S_MOVE;
            S_MOVE:   nxt = S_IDLE;
            default:  nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cap_en  = (state == S_QDATA);
        dec_en  = (state == S_DECIDE);
        move_en = (state == S_MOVE);
    end

`ifdef GHOST_FRIGHTENED_EN
    logic [15:0] lfsr;
    logic        fr_q;
    logic [1:0]  rnd_d;
`endif

    always_comb begin
        for (int i = 0; i < 4; i++)
            cost[i] = absdiff(nb_tx[i], tgt_x) + absdiff(nb_ty[i], tgt_y);
    end

    // Strict < over ascending index gives the UP > LEFT > DOWN > RIGHT tie order
    always_comb begin
        rev       = dir ^ 2'd2;
        cand      = nb_open & ~(4'b0001 << rev);
        dir_new   = rev;
        best_cost = '1;
        found     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (cand[i] && (!found || cost[i] < best_cost)) begin
                dir_new   = 2'(i);
                best_cost = cost[i];
                found     = 1'b1;
            end
        end
`ifdef GHOST_FRIGHTENED_EN
        rnd_d = 2'd0;
        if (frightened) begin
            found   = 1'b0;
            dir_new = rev;
            for (int j = 0; j < 4; j++) begin
                rnd_d = lfsr[1:0] + 2'(j);
                if (!found && cand[rnd_d]) begin
                    dir_new = rnd_d;
                    found   = 1'b1;
                end
            end
        end
`endif
        if (mode_flag && nb_open[rev]) dir_new = rev;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x         <= START_X;
            y         <= START_Y;
            dir       <= START_DIR;
            busy      <= 1'b0;
            wall_addr <= 10'd0;
            k         <= 2'd0;
            nb_open   <= 4'd0;
            tgt_x     <= 6'd0;
            tgt_y     <= 6'd0;
            chase_q   <= 1'b0;
            mode_flag <= 1'b0;
        end else begin
            busy <= (nxt != S_IDLE) || (state == S_MOVE);
            if (accept) begin
                tgt_x   <= chase ? pac_x[8:3] : 6'(SCATTER_TX);
                tgt_y   <= chase ? pac_y[8:3] : SCATTER_TY;
                chase_q <= chase;
                k       <= 2'd0;
                if (chase != chase_q) mode_flag <= 1'b1;
            end
            if (nxt == S_QADDR && nb_ok[qk])
                wall_addr <= 10'(int'(nb_ty[qk]) * MAZE_COLS + int'(nb_tx[qk]));
            if (cap_en) begin
                nb_open[k] <= nb_ok[k] & ~wall_bit;
                k          <= k + 2'd1;
            end
            if (dec_en) begin
                dir       <= dir_new;
                mode_flag <= 1'b0;
            end
`ifdef GHOST_FRIGHTENED_EN
            if (frightened && !fr_q) mode_flag <= 1'b1;
`endif
            if (move_en && !(aligned && !nb_open[dir])) begin
                case (dir)
                    D_UP:    y <= y - 9'd1;
                    D_LEFT:  x <= (x == 9'd0) ? X_LAST : x - 9'd1;
                    D_DOWN:  y <= y + 9'd1;
                    D_RIGHT: x <= (x == X_LAST) ? 9'd0 : x + 9'd1;
                    default: ;
                endcase
            end
        end
    end

`ifdef GHOST_FRIGHTENED_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= 16'hACE1;
            fr_q <= 1'b0;
        end else begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
            fr_q <= frightened;
        end
    end
`endif

endmodule
